dmem_sequencer: RTL and testbench

Memory-stage access sequencer for the five-stage pipeline. It sits between the M stage (fed by the execute/memory pipeline register) and a multi-cycle data memory with a request/acknowledge handshake. It holds the pipeline with `stall` while a load or store is outstanding, and returns load data with a one-cycle valid pulse. It also flags misaligned, illegal or timed-out accesses.

---
 rtl/dmem_sequencer.sv | 154 +++++++++++++++
 tb/tb_dmem_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sequencer
// Description : M-stage data-memory access sequencer. Turns a single-cycle
//               load/store request from the pipeline into a req/ack handshake
//               with a multi-cycle memory. The pipeline is held with stall
//               while the access is outstanding. Load data comes back with a
//               one-cycle valid pulse. Misaligned, illegal and timed-out
//               accesses raise a sticky fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_read,
    input  logic              m_write,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_val,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              fault,
    output logic [15:0]       stall_cnt
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [7:0]  c_TIMEOUT = 8'(TIMEOUT);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_tmo_cnt;
    logic [7:0]        w_tmo_inc;
    logic              w_acc;
    logic              w_legal;
    logic              w_timeout;
    logic              w_stall;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_load_data;
    logic              r_load_valid;
    logic              r_fault;
    logic [15:0]       r_stall_cnt;

    // An access is legal only when exactly one of read/write is set and the
    // address is word aligned.
    assign w_acc     = m_read | m_write;
    assign w_legal   = (m_read ^ m_write) && (m_addr[1:0] == 2'b00);
    // Timeout fires on the REQ cycle whose increment reaches TIMEOUT; an ack
    // in that same cycle takes priority.
    assign w_tmo_inc = r_tmo_cnt + 8'd1;
    assign w_timeout = !mem_ack && (w_tmo_inc == c_TIMEOUT);
    assign w_stall   = ((r_state == c_ST_IDLE) && w_legal) || (r_state == c_ST_REQ);

    assign mem_req    = (r_state == c_ST_REQ);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign stall      = w_stall;
    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign fault      = r_fault;
    assign stall_cnt  = r_stall_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: IDLE -> REQ on a legal access, REQ -> DONE on ack or
    // timeout, DONE always falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_legal) w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (mem_ack || w_timeout) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Request latch, timeout counter, load result and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_tmo_cnt    <= 8'd0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_legal) begin
                        r_mem_addr  <= m_addr;
                        r_mem_wdata <= m_val;
                        r_mem_we    <= m_write;
                        r_tmo_cnt   <= 8'd0;
                    end else if (w_acc) begin
                        r_fault <= 1'b1;
                    end
                end
                c_ST_REQ: begin
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_load_data  <= mem_rdata;
                            r_load_valid <= 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= w_tmo_inc;
                        if (w_timeout) begin
                            r_fault      <= 1'b1;
                            r_load_data  <= '0;
                            r_load_valid <= !r_mem_we;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_sequencer
// Description : Randomized self-checking bench for dmem_sequencer. Each
//               access is described as a transaction (ack delay, data) and
//               expanded into one expected output record per cycle; a single
//               compare process checks the DUT against those records.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_sequencer;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_read, m_write, mem_ack;
    logic [31:0] m_addr, m_val, mem_rdata;
    logic        mem_req, mem_we, stall, load_valid, fault;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [15:0] stall_cnt;

    dmem_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_val(m_val),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .fault(fault), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        bit          we;
        bit          stl;
        bit          lv;
        bit          flt;
        bit          chk_bus;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic [15:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Architectural model state, updated as transactions are issued.
    bit          m_fault = 1'b0;
    logic [31:0] m_ld    = 32'd0;
    logic [15:0] m_scnt  = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic exp_t mk(input bit req, input bit we, input bit stl, input bit lv,
                                input logic [31:0] addr, input logic [31:0] wdata, input bit chk_bus);
        exp_t e;
        e.req = req; e.we = we; e.stl = stl; e.lv = lv;
        e.addr = addr; e.wdata = wdata; e.chk_bus = chk_bus;
        e.flt = m_fault; e.ld = m_ld; e.scnt = m_scnt;
        return e;
    endfunction

    // Per-cycle compare of DUT outputs against the expected record.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("mem_req", {31'd0, mem_req}, {31'd0, e.req});
            check("stall", {31'd0, stall}, {31'd0, e.stl});
            check("load_valid", {31'd0, load_valid}, {31'd0, e.lv});
            check("load_data", load_data, e.ld);
            check("fault", {31'd0, fault}, {31'd0, e.flt});
            check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.scnt});
            if (e.req || e.chk_bus) begin
                check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata, e.wdata);
            end
        end
    end

    task automatic step(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] v, input bit ack, input logic [31:0] rdat);
        @(posedge clk);
        #1;
        rst = r; m_read = rd; m_write = wr; m_addr = a; m_val = v;
        mem_ack = ack; mem_rdata = rdat;
    endtask

    task automatic do_idle(input bit force_ack, input bit chk_bus);
        step(1'b0, 1'b0, 1'b0, $urandom, $urandom,
             force_ack | ($urandom_range(0, 3) == 0), $urandom);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, chk_bus));
    endtask

    // One instruction: k is the REQ cycle carrying ack (outside 1..T means
    // no ack, i.e. timeout); rst_at asserts reset in that REQ cycle.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] val, input int k,
                             input logic [31:0] rdat_v, input int rst_at);
        bit legal;
        bit tmo;
        int n;
        legal = (rd ^ wr) && (addr[1:0] == 2'b00);
        step(1'b0, rd, wr, addr, val, 1'($urandom_range(0, 1)), $urandom);
        exp_q.push_back(mk(1'b0, 1'b0, legal, 1'b0, 32'd0, 32'd0, 1'b0));
        if (!legal) begin
            if (rd | wr) m_fault = 1'b1;
            return;
        end
        m_scnt = sat_inc(m_scnt);
        tmo = !(k >= 1 && k <= T);
        n   = tmo ? T : k;
        for (int i = 1; i <= n; i++) begin
            step(i == rst_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, i == k, (i == k) ? rdat_v : $urandom);
            exp_q.push_back(mk(1'b1, wr, 1'b1, 1'b0, addr, val, 1'b0));
            if (i == rst_at) begin
                m_fault = 1'b0; m_ld = 32'd0; m_scnt = 16'd0;
                return;
            end
            m_scnt = sat_inc(m_scnt);
        end
        if (tmo) begin
            m_fault = 1'b1;
            m_ld    = 32'd0;
        end else if (rd) begin
            m_ld = rdat_v;
        end
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             1'($urandom_range(0, 1)), $urandom);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, rd, 32'd0, 32'd0, 1'b0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; m_read = 1'b0; m_write = 1'b0; m_addr = '0; m_val = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, including the latched bus.
        do_idle(1'b0, 1'b1);

        // Minimal load: 2 stall cycles, data in DONE.
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
        @(negedge clk);
        check("lit_load_valid", {31'd0, load_valid}, 32'd1);
        check("lit_load_data", load_data, 32'hDEADBEEF);
        check("lit_scnt_load", {16'd0, stall_cnt}, 32'd2);

        // Store with ack in 4th REQ cycle: 5 stall cycles, no load_valid.
        do_access(1'b0, 1'b1, 32'h204, 32'h12345678, 4, 32'h0, 0);
        @(negedge clk);
        check("lit_store_lv", {31'd0, load_valid}, 32'd0);
        check("lit_scnt_store", {16'd0, stall_cnt}, 32'd7);

        // Misaligned load.
        do_access(1'b1, 1'b0, 32'h103, 32'h0, 1, 32'h0, 0);
        do_idle(1'b0, 1'b0);
        @(negedge clk);
        check("lit_misalign_fault", {31'd0, fault}, 32'd1);
        check("lit_misalign_scnt", {16'd0, stall_cnt}, 32'd7);
        do_access(1'b1, 1'b0, 32'h108, 32'h0, 2, 32'h0BADF00D, 0);
        @(negedge clk);
        check("lit_fault_sticky", {31'd0, fault}, 32'd1);

        // Timeout on a load.
        do_access(1'b1, 1'b0, 32'h10C, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        check("lit_tmo_lv", {31'd0, load_valid}, 32'd1);
        check("lit_tmo_ld", load_data, 32'd0);
        check("lit_tmo_scnt", {16'd0, stall_cnt}, 32'd26);

        // Back-to-back loads.
        do_access(1'b1, 1'b0, 32'h400, 32'h0, 1, 32'hAAAA5555, 0);
        do_access(1'b1, 1'b0, 32'h404, 32'h0, 2, 32'h5555AAAA, 0);
        @(negedge clk);
        check("lit_b2b_ld", load_data, 32'h5555AAAA);

        // Reset during REQ, then a stray ack.
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0, 3);
        do_idle(1'b1, 1'b1);
        @(negedge clk);
        check("lit_rst_scnt", {16'd0, stall_cnt}, 32'd0);
        check("lit_rst_req", {31'd0, mem_req}, 32'd0);
        do_idle(1'b1, 1'b0);
        @(negedge clk);
        check("lit_rst_stray_lv", {31'd0, load_valid}, 32'd0);

        // Ack on the last allowed REQ cycle wins over timeout.
        do_access(1'b1, 1'b0, 32'h40, 32'h0, T, 32'hCAFEF00D, 0);
        @(negedge clk);
        check("lit_edge_fault", {31'd0, fault}, 32'd0);
        check("lit_edge_ld", load_data, 32'hCAFEF00D);
        check("lit_edge_scnt", {16'd0, stall_cnt}, 32'd16);

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 3) begin
                do_idle(1'b0, 1'b0);
            end else if (r == 3) begin
                if ($urandom_range(0, 1) == 1)
                    do_access(1'b1, 1'b1, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom, 1, $urandom, 0);
                else
                    do_access(1'($urandom_range(0, 1)), 1'b0,
                              {$urandom_range(0, 32'h3FFFFFFF), 2'($urandom_range(1, 3))}, $urandom, 1, $urandom, 0);
            end else if (r == 4) begin
                do_access(1'b1, 1'b0, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom, 0, $urandom,
                          $urandom_range(1, T));
                do_idle(1'b1, 1'b1);
            end else begin
                bit rd;
                int k;
                rd = 1'($urandom_range(0, 1));
                k  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 3) : $urandom_range(1, 4);
                do_access(rd, !rd, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom, k, $urandom, 0);
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
